mcpu_boot_mem: RTL
==================

Name: mcpu_boot_mem

Overview:
- On-chip 64x8 program/data memory that sits directly downstream of the mcpu core's bus (address, oe, we, dataout) and returns read data on the core's datain path.
- Contains a byte-serial loader fed from the otherwise-unused dedicated inputs.
- After reset it holds the core in reset, accepts exactly DEPTH bytes into addresses 0..DEPTH-1, then releases the core to run from the loaded image.

Parameters:
- AW, 6, address width (matches the core's 6-bit address bus)
- DW, 8, data width
- DEPTH, 64, number of words; must equal 2**AW

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cpu_addr  input  AW  core address
- cpu_oe  input  1  core read strobe
- cpu_we  input  1  core write strobe
- cpu_wdata  input  DW  core write data
- cpu_rdata  output  DW  read data to core
- cpu_rst_n  output  1  active-low reset to core (registered)
- ld_valid  input  1  loader byte valid
- ld_data  input  DW  loader byte
- ld_ready  output  1  loader can accept a byte
- ld_skip  input  1  leave LOAD without loading; keep current contents
- ld_restart  input  1  return to LOAD from RUN
- ld_done  output  1  high while in RUN
- ld_count  output  AW+1  bytes accepted in current load, 0..DEPTH
- ld_csum  output  DW  loader checksum (see Optional Feature)

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous active-low, no synchroniser inside the block. All flops clear on rst_n low.
- States: LOAD, RUN. Reset enters LOAD.
- Reset values: cpu_rst_n=0, ld_ready=0, ld_done=0, ld_count=0, ld_csum=0, cpu_rdata=0. The memory array is NOT reset, so its contents survive rst_n.
- ld_ready is registered. It goes to 1 on the first clk edge after rst_n deasserts while in LOAD; it is 0 in RUN.
- LOAD:
  - A byte is accepted on a clk edge where ld_valid && ld_ready. It is written to mem[ld_count[AW-1:0]] and ld_count increments.
  - When the DEPTH-th byte is accepted, ld_count=DEPTH, the state goes to RUN on the same edge, and ld_ready drops.
  - ld_skip=1 in LOAD goes to RUN on the next edge. If ld_valid && ld_ready on that same edge, the byte is still written first; skip wins the state change.
  - Core writes are ignored in LOAD.
- RUN:
  - ld_done=1. cpu_rst_n rises one edge after entering RUN, so the core sees a full cycle of stable memory.
  - ld_restart=1: next edge goes to LOAD, ld_count=0, ld_csum=0, cpu_rst_n=0, ld_done=0. ld_ready returns to 1 one edge later. Contents are kept.
  - ld_restart is ignored in LOAD; ld_skip is ignored in RUN.
- Core read:
  - cpu_rdata = cpu_oe ? mem[cpu_addr] : 0. This is an asynchronous read with zero latency, valid in both states.
- Core write:
  - On a clk edge with cpu_we=1 in RUN, mem[cpu_addr] <= cpu_wdata.
  - oe and we together: the write happens, and cpu_rdata shows the pre-write word during that cycle.
- ld_count saturates at DEPTH. No wrap-around writes.
- rst_n asserted mid-load or mid-run: state goes to LOAD immediately, the core is held, and partial contents stay in the array.

Optional Feature:
- Macro: MCPU_MEM_CHECKSUM_EN.
- When defined: ld_csum is an 8-bit modular sum of all bytes accepted since the last reset or restart. It updates on the same edge as each write and is held in RUN.
- When undefined: ld_csum is tied to 0 and no adder is built.

Decomposition:
- Package mcpu_mem_pkg holds:
  - the state enum (LOAD, RUN);
  - AW, DW, DEPTH defaults;
  - a localparam for the count width AW+1.
- Sub-module mcpu_mem_array: DEPTH x DW flop array with one synchronous write port (we, waddr, wdata) and one asynchronous read port. The top-level muxes the write port between loader and core by state.

Test Plan:
- Load walk: reset, stream 64 bytes 0x00..0x3F with ld_valid held high -> ld_count reaches 64 on the 64th accept; ld_done=1 next cycle; cpu_rst_n=1 one edge later; oe reads at addr 0x15 return 0x15.
- Backpressure: drop ld_valid every other cycle -> only valid&&ready bytes are written; no duplicates or skips; ld_count is exact.
- Core write: in RUN, we=1, addr=0x3F, wdata=0xA5 -> next-cycle read at 0x3F returns 0xA5. Same write during LOAD -> the word is unchanged.
- Skip/restart: reset, assert ld_skip with no bytes loaded -> RUN with old contents; pulse ld_restart -> cpu_rst_n=0, ld_count=0, ld_ready=1 after one edge.
- Reset mid-load: pull rst_n low after 10 bytes -> cpu_rst_n=0 asynchronously; reload writes from address 0; bytes 10..63 keep their prior values.
- Checksum (MCPU_MEM_CHECKSUM_EN): load 64 x 0x05 -> ld_csum=0x40. Without the macro -> ld_csum=0x00.

Source files
------------

// File: rtl/mcpu_mem_pkg.sv
// Shared types and default geometry for the mcpu boot memory.
// Used by mcpu_mem_array and mcpu_boot_mem.
package mcpu_mem_pkg;

  localparam int MEM_AW    = 6;
  localparam int MEM_DW    = 8;
  localparam int MEM_DEPTH = 64;
  localparam int MEM_CW    = MEM_AW + 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mcpu_mem_array.sv
// DEPTH x DW flop array: one synchronous write port, one zero-latency read port.
// Contents are deliberately not reset so an image survives rst_n.
module mcpu_mem_array
  import mcpu_mem_pkg::*;
#(
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] word_we;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = we && (waddr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (word_we[i]) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mcpu_boot_mem.sv
// Boot memory for the mcpu core: byte-serial loader fills the array, then the core runs from it.
// Define MCPU_MEM_CHECKSUM_EN to build the loader checksum; otherwise ld_csum is tied to zero.
module mcpu_boot_mem
  import mcpu_mem_pkg::*;
#(
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rst_n,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          ld_skip,
  input  logic          ld_restart,
  output logic          ld_done,
  output logic [AW:0]   ld_count,
  output logic [DW-1:0] ld_csum
);

  localparam int CW = AW + 1;

  state_e        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_reg, ready_next;
  logic          cpu_rst_n_reg, cpu_rst_n_next;
  logic          ld_accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ld_accept  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cpu_addr;
    mem_wdata  = cpu_wdata;
    case (state_reg)
      ST_LOAD: begin
        // Loader owns the write port; core writes are dropped here.
        ld_accept = ld_valid && ready_reg && (count_reg < CW'(DEPTH));
        mem_we    = ld_accept;
        mem_waddr = count_reg[AW-1:0];
        mem_wdata = ld_data;
        if (ld_accept) count_next = count_reg + CW'(1);
        if (ld_skip || (ld_accept && (count_reg == CW'(DEPTH - 1)))) state_next = ST_RUN;
      end
      ST_RUN: begin
        mem_we = cpu_we;
        if (ld_restart) begin
          state_next = ST_LOAD;
          count_next = '0;
        end
      end
      default: state_next = ST_LOAD;
    endcase
    // Both flags need a full cycle in the same state before asserting.
    ready_next     = (state_reg == ST_LOAD) && (state_next == ST_LOAD);
    cpu_rst_n_next = (state_reg == ST_RUN) && (state_next == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_LOAD;
      count_reg     <= '0;
      ready_reg     <= 1'b0;
      cpu_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      ready_reg     <= ready_next;
      cpu_rst_n_reg <= cpu_rst_n_next;
    end
  end

`ifdef MCPU_MEM_CHECKSUM_EN
  logic [DW-1:0] csum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else if ((state_reg == ST_RUN) && ld_restart) begin
      csum_reg <= '0;
    end else if (ld_accept) begin
      csum_reg <= csum_reg + ld_data;
    end
  end

  assign ld_csum = csum_reg;
`else
  assign ld_csum = '0;
`endif

  mcpu_mem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cpu_addr),
    .rdata (mem_rdata)
  );

  assign cpu_rdata = cpu_oe ? mem_rdata : '0;
  assign cpu_rst_n = cpu_rst_n_reg;
  assign ld_ready  = ready_reg;
  assign ld_done   = (state_reg == ST_RUN);
  assign ld_count  = count_reg;

endmodule
